fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 16-bit LC-3b pipelined core.
- Owns the architectural PC register and the IF→DE pipeline latch (de_npc, de_ir, de_v).
- Drives the instruction-memory address, selects the next PC (sequential, branch target, or trap vector), and handles dependency, memory and branch stalls.
- Sits between the instruction memory port and the decode stage; redirect and stall inputs come from later stages.

Parameters:
- RESET_PC, 16'h3000, PC value loaded on reset (user program start).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; forces all registers to reset values.
- dep_stall  in  1  decode-stage data-dependency stall.
- mem_stall  in  1  memory stage waiting on data memory.
- v_de_br_stall  in  1  valid control instruction (BR/JMP/JSR/TRAP) in DE.
- v_agex_br_stall  in  1  valid control instruction in AGEX.
- v_mem_br_stall  in  1  valid control instruction in MEM; redirect resolved this cycle.
- mem_pcmux  in  2  next-PC select from MEM: 0=PC+2, 1=target_pc, 2=trap_pc, 3=PC+2 (reserved).
- target_pc  in  16  branch/jump target computed in AGEX/MEM.
- trap_pc  in  16  trap vector data read in MEM.
- instr  in  16  instruction word from instruction memory at address pc.
- imem_r  in  1  instruction memory ready; instr valid this cycle.
- pc  out  16  current PC register; instruction memory read address.
- new_pc  out  16  combinational next-PC mux output.
- ld_pc  out  1  combinational PC load enable.
- ld_de  out  1  combinational DE latch load enable.
- de_npc  out  16  registered PC+2 of the latched instruction.
- de_ir  out  16  registered instruction word.
- de_v  out  1  registered valid bit of DE latch.

Behaviour:
- Reset (async, any time, including mid-stall):
  - pc=RESET_PC, de_npc=0, de_ir=0, de_v=0.
  - Combinational outputs follow inputs; no register loads while reset is high.
- pc_plus2 = pc + 2, modulo 2^16 (16'hFFFE → 16'h0000).
- new_pc:
  - mem_pcmux=1 → target_pc; mem_pcmux=2 → trap_pc.
  - mem_pcmux=0 or 3 → pc_plus2.
- any_br = v_de_br_stall | v_agex_br_stall | v_mem_br_stall.
- ld_pc:
  - Redirect case: 1 when v_mem_br_stall & (mem_pcmux==1 | mem_pcmux==2) & !mem_stall. Redirect has priority over all other stall conditions except mem_stall.
  - Sequential case: otherwise 1 when imem_r & !dep_stall & !mem_stall & !any_br.
  - Otherwise 0.
  - A not-taken branch in MEM (mem_pcmux=0) does not load; pc already holds the fall-through address.
- ld_de = !dep_stall & !mem_stall.
- DE latch input:
  - npc = pc_plus2; ir = instr.
  - v = imem_r & !any_br. A bubble is inserted while the instruction is not ready or any control instruction is in flight.
- Rising clk (reset low):
  - if ld_pc, pc <= new_pc.
  - if ld_de, latch npc/ir/v into de_npc/de_ir/de_v.
  - Otherwise registers hold.
- Latency: an instruction present on instr with imem_r=1 appears on de_ir one clock later; the fetch after it uses pc+2.
- Simultaneous dep_stall and redirect: pc loads the redirect target and the DE latch holds.
- Simultaneous mem_stall and redirect: nothing loads; the redirect is retried next cycle.
- ld_de=1 with v=0 writes de_v=0; de_ir/de_npc still load and are don't-care.

Test Plan:
- Reset asserted mid-run → pc=16'h3000, de_v=0, de_ir=0, de_npc=0 immediately, without waiting for a clock edge.
- No stalls, imem_r=1, instr=16'h1234 at pc=16'h3000 → after 1 clk: pc=16'h3002, de_ir=16'h1234, de_npc=16'h3002, de_v=1.
- imem_r=0 → ld_pc=0; pc holds 16'h3000; after clk de_v=0.
- dep_stall=1 → ld_de=0, ld_pc=0; pc and DE latch hold for all cycles stall is high.
- v_de_br_stall=1 → pc holds, de_v=0 bubbles. Then v_mem_br_stall=1, mem_pcmux=1, target_pc=16'h4000 → new_pc=16'h4000, ld_pc=1, pc=16'h4000 after clk.
- v_mem_br_stall=1, mem_pcmux=2, trap_pc=16'h0200 → pc=16'h0200 after clk. Same with mem_stall=1 → no load. pc=16'hFFFE sequential → pc=16'h0000.

Source files
------------

// File: rtl/fetch_stage.sv
// LC-3b instruction-fetch stage. It owns the architectural PC and the IF->DE pipeline latch,
// selects the next PC (sequential, branch target or trap vector) and applies the pipeline stalls.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dep_stall,
  input  logic        mem_stall,
  input  logic        v_de_br_stall,
  input  logic        v_agex_br_stall,
  input  logic        v_mem_br_stall,
  input  logic [1:0]  mem_pcmux,
  input  logic [15:0] target_pc,
  input  logic [15:0] trap_pc,
  input  logic [15:0] instr,
  input  logic        imem_r,
  output logic [15:0] pc,
  output logic [15:0] new_pc,
  output logic        ld_pc,
  output logic        ld_de,
  output logic [15:0] de_npc,
  output logic [15:0] de_ir,
  output logic        de_v
);

  typedef enum logic [1:0] {
    PCMUX_SEQ  = 2'd0,
    PCMUX_TGT  = 2'd1,
    PCMUX_TRAP = 2'd2,
    PCMUX_RSVD = 2'd3
  } pcmux_e;

  logic [15:0] pc_q, pc_d;
  logic [15:0] de_npc_q, de_npc_d;
  logic [15:0] de_ir_q, de_ir_d;
  logic        de_v_q, de_v_d;

  logic [15:0] pc_plus2;
  logic        any_br;
  logic        redirect;

  // Wraps modulo 2^16, so 16'hFFFE advances to 16'h0000.
  assign pc_plus2 = pc_q + 16'd2;
  assign any_br   = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;

  // A taken redirect from MEM overrides every stall except a stalled MEM stage.
  assign redirect = v_mem_br_stall & !mem_stall &
                    ((pcmux_e'(mem_pcmux) == PCMUX_TGT) | (pcmux_e'(mem_pcmux) == PCMUX_TRAP));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    new_pc = pc_plus2;
    case (pcmux_e'(mem_pcmux))
      PCMUX_TGT:  new_pc = target_pc;
      PCMUX_TRAP: new_pc = trap_pc;
      default:    new_pc = pc_plus2;
    endcase
  end

  assign ld_pc = redirect | (imem_r & !dep_stall & !mem_stall & !any_br);
  assign ld_de = !dep_stall & !mem_stall;

  always_comb begin
    pc_d     = pc_q;
    de_npc_d = de_npc_q;
    de_ir_d  = de_ir_q;
    de_v_d   = de_v_q;
    if (ld_pc) pc_d = new_pc;
    // A bubble enters DE while the fetch is not ready or a control instruction is in flight.
    if (ld_de) begin
      de_npc_d = pc_plus2;
      de_ir_d  = instr;
      de_v_d   = imem_r & !any_br;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      de_npc_q <= '0;
      de_ir_q  <= '0;
      de_v_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      de_npc_q <= de_npc_d;
      de_ir_q  <= de_ir_d;
      de_v_q   <= de_v_d;
    end
  end

  assign pc     = pc_q;
  assign de_npc = de_npc_q;
  assign de_ir  = de_ir_q;
  assign de_v   = de_v_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        dep_stall, mem_stall;
  logic        v_de_br_stall, v_agex_br_stall, v_mem_br_stall;
  logic [1:0]  mem_pcmux;
  logic [15:0] target_pc, trap_pc, instr;
  logic        imem_r;
  logic [15:0] pc, new_pc, de_npc, de_ir;
  logic        ld_pc, ld_de, de_v;

  int vectors     = 0;
  int miscompares = 0;

  // Model state
  logic [15:0] m_pc, m_npc, m_ir;
  logic        m_v;

  fetch_stage #(.RESET_PC(16'h3000)) dut (
    .clk(clk), .reset(reset),
    .dep_stall(dep_stall), .mem_stall(mem_stall),
    .v_de_br_stall(v_de_br_stall), .v_agex_br_stall(v_agex_br_stall),
    .v_mem_br_stall(v_mem_br_stall), .mem_pcmux(mem_pcmux),
    .target_pc(target_pc), .trap_pc(trap_pc), .instr(instr), .imem_r(imem_r),
    .pc(pc), .new_pc(new_pc), .ld_pc(ld_pc), .ld_de(ld_de),
    .de_npc(de_npc), .de_ir(de_ir), .de_v(de_v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_new_pc();
    if (mem_pcmux == 2'd1) return target_pc;
    if (mem_pcmux == 2'd2) return trap_pc;
    return m_pc + 16'd2;
  endfunction

  function automatic logic exp_ld_pc();
    logic taken_redirect;
    logic branches_in_flight;
    taken_redirect     = v_mem_br_stall && (mem_pcmux == 2'd1 || mem_pcmux == 2'd2) && !mem_stall;
    branches_in_flight = v_de_br_stall || v_agex_br_stall || v_mem_br_stall;
    return taken_redirect || (imem_r && !dep_stall && !mem_stall && !branches_in_flight);
  endfunction

  function automatic logic exp_ld_de();
    return !dep_stall && !mem_stall;
  endfunction

  task automatic model_reset();
    m_pc = 16'h3000; m_npc = 16'h0000; m_ir = 16'h0000; m_v = 1'b0;
  endtask

  task automatic drive(input logic ds, input logic ms, input logic bde, input logic bag,
                       input logic bme, input logic [1:0] mux, input logic [15:0] tgt,
                       input logic [15:0] trp, input logic [15:0] ins, input logic rdy);
    dep_stall = ds; mem_stall = ms; v_de_br_stall = bde; v_agex_br_stall = bag;
    v_mem_br_stall = bme; mem_pcmux = mux; target_pc = tgt; trap_pc = trp;
    instr = ins; imem_r = rdy;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".pc"},     pc,     m_pc);
    check({tag, ".de_npc"}, de_npc, m_npc);
    check({tag, ".de_ir"},  de_ir,  m_ir);
    check({tag, ".de_v"},   {15'd0, de_v}, {15'd0, m_v});
  endtask

  // Check combinational outputs, advance one clock, then check the registered state.
  task automatic cycle(input string tag);
    logic [15:0] n_pc, n_npc, n_ir;
    logic        n_v;
    #1;
    check({tag, ".new_pc"}, new_pc, exp_new_pc());
    check({tag, ".ld_pc"},  {15'd0, ld_pc}, {15'd0, exp_ld_pc()});
    check({tag, ".ld_de"},  {15'd0, ld_de}, {15'd0, exp_ld_de()});
    n_pc = m_pc; n_npc = m_npc; n_ir = m_ir; n_v = m_v;
    if (!reset) begin
      if (exp_ld_pc()) n_pc = exp_new_pc();
      if (exp_ld_de()) begin
        n_npc = m_pc + 16'd2;
        n_ir  = instr;
        n_v   = imem_r && !(v_de_br_stall || v_agex_br_stall || v_mem_br_stall);
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_npc = n_npc; m_ir = n_ir; m_v = n_v;
    check_regs(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_regs(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 2'd0, 16'h0, 16'h0, 16'h0, 1'b0);
    model_reset();
    #2;
    check_regs("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Plain sequential fetch
    drive(0, 0, 0, 0, 0, 2'd0, 16'h0, 16'h0, 16'h1234, 1'b1);
    cycle("seq");
    check("seq.pc_abs", pc, 16'h3002);
    check("seq.ir_abs", de_ir, 16'h1234);

    // Instruction memory not ready
    drive(0, 0, 0, 0, 0, 2'd0, 16'h0, 16'h0, 16'hBEEF, 1'b0);
    cycle("imem_wait");

    // Dependency stall holds everything
    drive(1, 0, 0, 0, 0, 2'd0, 16'h0, 16'h0, 16'h5678, 1'b1);
    repeat (3) cycle("dep_stall");

    // Branch in DE: bubbles, then MEM redirect to target
    drive(0, 0, 1, 0, 0, 2'd0, 16'h0, 16'h0, 16'h0E05, 1'b1);
    repeat (2) cycle("br_de");
    drive(0, 0, 0, 0, 1, 2'd1, 16'h4000, 16'h0, 16'h0E05, 1'b1);
    cycle("redirect");
    check("redirect.pc_abs", pc, 16'h4000);

    // Trap redirect blocked by mem_stall, then taken
    drive(0, 1, 0, 0, 1, 2'd2, 16'h0, 16'h0200, 16'hF025, 1'b1);
    cycle("trap_memstall");
    drive(0, 0, 0, 0, 1, 2'd2, 16'h0, 16'h0200, 16'hF025, 1'b1);
    cycle("trap");
    check("trap.pc_abs", pc, 16'h0200);

    // Redirect with dep_stall: pc loads, DE holds
    drive(1, 0, 0, 0, 1, 2'd1, 16'hFFFE, 16'h0, 16'h1111, 1'b1);
    cycle("redirect_dep");

    // Not-taken branch in MEM does not load
    drive(0, 0, 0, 0, 1, 2'd0, 16'h1234, 16'h0, 16'h2222, 1'b1);
    cycle("not_taken");

    // Wraparound 0xFFFE -> 0x0000
    drive(0, 0, 0, 0, 0, 2'd3, 16'h0, 16'h0, 16'h3333, 1'b1);
    cycle("wrap");
    check("wrap.pc_abs", pc, 16'h0000);

    // Reset in the middle of a stall
    drive(1, 1, 0, 1, 0, 2'd1, 16'h7777, 16'h0, 16'h4444, 1'b1);
    async_reset_pulse("reset_mid");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)),
            16'($urandom), 16'($urandom), 16'($urandom),
            $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 60) == 0) async_reset_pulse("rand_reset");
      else cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
